// File: rtl/dualportram_arbiter.sv
// Two-client front end for one simple dual-port RAM. The read port and the write
// port each have their own round-robin arbiter, and reads return on a 2-cycle pipeline.
module dualportram_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10,
    parameter int WORDS = 1024
) (
    input  logic             clk,
    input  logic             reset,
    output logic [31:0]      length,

    input  logic             a_rd_req,
    input  logic [31:0]      a_raddr,
    output logic             a_rd_gnt,
    output logic [WIDTH-1:0] a_rdata,
    output logic             a_rvalid,
    input  logic             a_wr_req,
    input  logic [31:0]      a_waddr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_wr_gnt,

    input  logic             b_rd_req,
    input  logic [31:0]      b_raddr,
    output logic             b_rd_gnt,
    output logic [WIDTH-1:0] b_rdata,
    output logic             b_rvalid,
    input  logic             b_wr_req,
    input  logic [31:0]      b_waddr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_wr_gnt,

    output logic [31:0]      ram_raddress,
    output logic [31:0]      ram_waddress,
    output logic [WIDTH-1:0] ram_din,
    output logic             ram_we,
    input  logic [WIDTH-1:0] ram_dout
);

    typedef enum logic {CL_A = 1'b0, CL_B = 1'b1} client_t;

    client_t          r_rd_last;
    client_t          r_wr_last;
    logic             w_a_rd_gnt;
    logic             w_b_rd_gnt;
    logic             w_a_wr_gnt;
    logic             w_b_wr_gnt;
    logic             r_vld_p1;
    logic             r_vld_p2;
    client_t          r_own_p1;
    client_t          r_own_p2;
    logic [31:0]      r_raddr;
    logic [31:0]      r_waddr;
    logic [WIDTH-1:0] r_din;
    logic             r_we;

    // Never advertise more words than the address width can actually reach.
    assign length = (WORDS <= (1 << DEPTH)) ? 32'(WORDS) : 32'(1 << DEPTH);

    always_comb begin
        w_a_rd_gnt = 1'b0;
        w_b_rd_gnt = 1'b0;
        w_a_wr_gnt = 1'b0;
        w_b_wr_gnt = 1'b0;
        if (!reset) begin
            w_a_rd_gnt = a_rd_req && (!b_rd_req || r_rd_last == CL_B);
            w_b_rd_gnt = b_rd_req && (!a_rd_req || r_rd_last == CL_A);
            w_a_wr_gnt = a_wr_req && (!b_wr_req || r_wr_last == CL_B);
            w_b_wr_gnt = b_wr_req && (!a_wr_req || r_wr_last == CL_A);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_last <= CL_B;
            r_wr_last <= CL_B;
            r_raddr   <= '0;
            r_waddr   <= '0;
            r_din     <= '0;
            r_we      <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_own_p1  <= CL_A;
            r_own_p2  <= CL_A;
        end else begin
            // Stage p1: accepted read address launched to the RAM.
            if (w_a_rd_gnt || w_b_rd_gnt) begin
                r_rd_last <= w_b_rd_gnt ? CL_B : CL_A;
                r_raddr   <= w_b_rd_gnt ? b_raddr : a_raddr;
            end
            r_vld_p1 <= w_a_rd_gnt || w_b_rd_gnt;
            r_own_p1 <= w_b_rd_gnt ? CL_B : CL_A;
            // Stage p2: RAM has registered dout for the p1 read.
            r_vld_p2 <= r_vld_p1;
            r_own_p2 <= r_own_p1;

            r_we <= w_a_wr_gnt || w_b_wr_gnt;
            if (w_a_wr_gnt || w_b_wr_gnt) begin
                r_wr_last <= w_b_wr_gnt ? CL_B : CL_A;
                r_waddr   <= w_b_wr_gnt ? b_waddr : a_waddr;
                r_din     <= w_b_wr_gnt ? b_wdata : a_wdata;
            end
        end
    end

    assign a_rd_gnt     = w_a_rd_gnt;
    assign b_rd_gnt     = w_b_rd_gnt;
    assign a_wr_gnt     = w_a_wr_gnt;
    assign b_wr_gnt     = w_b_wr_gnt;
    assign a_rvalid     = r_vld_p2 && (r_own_p2 == CL_A);
    assign b_rvalid     = r_vld_p2 && (r_own_p2 == CL_B);
    assign a_rdata      = ram_dout;
    assign b_rdata      = ram_dout;
    assign ram_raddress = r_raddr;
    assign ram_waddress = r_waddr;
    assign ram_din      = r_din;
    assign ram_we       = r_we;

endmodule
